// File: rtl/rotate_sequencer.sv
// Multi-step rotate engine: applies CNT single-position rotations, one per clock, to a word.
// Latency: CNT cycles of rotation after acceptance, result valid the following cycle (CNT=0 -> next cycle).
// Backpressure: result and OUT_VALID hold while OUT_READY=0; no new job accepted until the result is consumed.
module rotate_sequencer #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [N-1:0]  X,
  input  logic          DIR,
  input  logic [CW-1:0] CNT,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [N-1:0]  Y,
  output logic          BUSY
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ROTATE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  data_reg;
  logic [CW-1:0] rem;
  logic          dir_reg;
  logic          out_valid_reg;
  logic          busy_reg;
  logic [N-1:0]  step_data;

  // Single-step rotator fed back from data_reg: right wraps LSB to MSB, left wraps MSB to LSB.
  always_comb begin
    step_data = data_reg;
    if (dir_reg) begin
      step_data = {data_reg[0], data_reg[N-1:1]};
    end else begin
      step_data = {data_reg[N-2:0], data_reg[N-1]};
    end
  end

  // Job FSM: load in IDLE, rotate once per edge in ROTATE, present and hold the result in HOLD.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= S_IDLE;
      data_reg      <= '0;
      rem           <= '0;
      dir_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (IN_VALID) begin
            data_reg <= X;
            dir_reg  <= DIR;
            rem      <= CNT;
            if (CNT == '0) begin
              state         <= S_HOLD;
              out_valid_reg <= 1'b1;
            end else begin
              state    <= S_ROTATE;
              busy_reg <= 1'b1;
            end
          end
        end
        S_ROTATE: begin
          data_reg <= step_data;
          // rem is never zero here; the guard just keeps it from wrapping if it ever were.
          rem      <= (rem == '0) ? '0 : rem - CW'(1);
          if (rem <= CW'(1)) begin
            state         <= S_HOLD;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b1;
          end
        end
        S_HOLD: begin
          if (OUT_READY) begin
            state         <= S_IDLE;
            out_valid_reg <= 1'b0;
          end
        end
        default: begin
          state         <= S_IDLE;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  // Ready is a pure state decode, held low while reset is asserted.
  assign IN_READY  = (state == S_IDLE) && !RST;
  assign OUT_VALID = out_valid_reg;
  assign BUSY      = busy_reg;
  assign Y         = data_reg;

endmodule

// File: tb/tb_rotate_sequencer.sv
// Self-checking bench for rotate_sequencer: scoreboard of expected results, per-cycle
// checks of intermediate rotation values, BUSY length, backpressure hold and mid-job reset.
module tb_rotate_sequencer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       IN_VALID;
  logic       IN_READY;
  logic [7:0] X;
  logic       DIR;
  logic [3:0] CNT;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [7:0] Y;
  logic       BUSY;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  rotate_sequencer #(.N(8), .CW(4)) dut (
    .CLK(CLK),
    .RST(RST),
    .IN_VALID(IN_VALID),
    .IN_READY(IN_READY),
    .X(X),
    .DIR(DIR),
    .CNT(CNT),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .Y(Y),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rot1(input logic [7:0] d, input logic dir);
    if (dir) return {d[0], d[7:1]};
    else     return {d[6:0], d[7]};
  endfunction

  function automatic logic [7:0] rotn(input logic [7:0] d, input logic dir, input int n);
    logic [7:0] r;
    r = d;
    for (int i = 0; i < n; i++) r = rot1(r, dir);
    return r;
  endfunction

  // Wait for IN_READY (bounded), drive one job, push its expected result.
  task automatic start_job(input logic [7:0] x, input logic dir, input logic [3:0] cnt,
                           input logic [7:0] exp);
    int w;
    w = 0;
    while (!IN_READY && w < 50) begin
      @(negedge CLK);
      w++;
    end
    check("in_ready_before_job", int'(IN_READY), 1);
    IN_VALID = 1'b1;
    X        = x;
    DIR      = dir;
    CNT      = cnt;
    exp_q.push_back(exp);
    @(negedge CLK);
    IN_VALID = 1'b0;
    X        = 8'h00;
  endtask

  // Follow the job cycle by cycle until OUT_VALID, checking intermediate values and BUSY length.
  task automatic wait_done(input logic [7:0] x, input logic dir, input int cnt);
    int j;
    int busy_cnt;
    int mid_bad;
    j        = 0;
    busy_cnt = 0;
    mid_bad  = 0;
    while (!OUT_VALID && j < 40) begin
      if (BUSY) busy_cnt++;
      if (Y != rotn(x, dir, j)) mid_bad++;
      if (IN_READY) mid_bad++;
      @(negedge CLK);
      j++;
    end
    check("mid_values_bad", mid_bad, 0);
    check("latency", j, cnt);
    check("busy_cycles", busy_cnt, cnt);
    check("busy_low_in_hold", int'(BUSY), 0);
    check("in_ready_low_in_hold", int'(IN_READY), 0);
  endtask

  // Consume the result and compare against the scoreboard.
  task automatic drain();
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 0, 1);
      e = 8'h00;
    end else begin
      e = exp_q.pop_front();
    end
    check("y_result", int'(Y), int'(e));
    check("out_valid_at_result", int'(OUT_VALID), 1);
    OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
    check("out_valid_after_consume", int'(OUT_VALID), 0);
    check("in_ready_after_consume", int'(IN_READY), 1);
  endtask

  task automatic run_job(input logic [7:0] x, input logic dir, input logic [3:0] cnt,
                         input logic [7:0] exp);
    start_job(x, dir, cnt, exp);
    wait_done(x, dir, int'(cnt));
    drain();
  endtask

  initial begin
    logic [7:0] rx;
    logic       rd;
    logic [3:0] rc;
    int         bp_bad;

    RST       = 1'b1;
    IN_VALID  = 1'b0;
    X         = 8'h00;
    DIR       = 1'b0;
    CNT       = 4'd0;
    OUT_READY = 1'b0;

    // Reset state
    @(negedge CLK);
    @(negedge CLK);
    check("rst_y", int'(Y), 0);
    check("rst_out_valid", int'(OUT_VALID), 0);
    check("rst_busy", int'(BUSY), 0);
    check("rst_in_ready_forced_low", int'(IN_READY), 0);
    RST = 1'b0;
    #1;
    check("in_ready_after_rst", int'(IN_READY), 1);
    @(negedge CLK);

    // Directed cases from the plan
    run_job(8'b1001_0110, 1'b1, 4'd1, 8'b0100_1011);
    run_job(8'h81, 1'b0, 4'd3, 8'h0C);
    run_job(8'hA5, 1'b1, 4'd0, 8'hA5);
    run_job(8'h01, 1'b1, 4'd9, 8'h80);

    // Backpressure: result held for 5 cycles while IN_VALID pulses with other data
    start_job(8'h3C, 1'b1, 4'd2, 8'h0F);
    wait_done(8'h3C, 1'b1, 2);
    bp_bad = 0;
    for (int i = 0; i < 5; i++) begin
      IN_VALID = i[0] ? 1'b0 : 1'b1;
      X        = 8'hE7;
      DIR      = 1'b0;
      CNT      = 4'd1;
      @(negedge CLK);
      if (Y != 8'h0F) bp_bad++;
      if (!OUT_VALID) bp_bad++;
      if (IN_READY) bp_bad++;
      if (BUSY) bp_bad++;
    end
    IN_VALID = 1'b0;
    X        = 8'h00;
    check("backpressure_unstable", bp_bad, 0);
    drain();
    check("y_kept_in_idle", int'(Y), 8'h0F);
    @(negedge CLK);
    check("no_stray_job_out_valid", int'(OUT_VALID), 0);
    check("no_stray_job_busy", int'(BUSY), 0);

    // Reset during the second ROTATE cycle of a CNT=5 job
    start_job(8'h5A, 1'b0, 4'd5, 8'h00);
    void'(exp_q.pop_back());
    check("rst_job_busy_c1", int'(BUSY), 1);
    @(negedge CLK);
    check("rst_job_busy_c2", int'(BUSY), 1);
    RST = 1'b1;
    @(negedge CLK);
    check("midjob_rst_busy", int'(BUSY), 0);
    check("midjob_rst_out_valid", int'(OUT_VALID), 0);
    check("midjob_rst_y", int'(Y), 0);
    check("midjob_rst_in_ready", int'(IN_READY), 0);
    RST = 1'b0;
    bp_bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (OUT_VALID) bp_bad++;
      if (!IN_READY) bp_bad++;
    end
    check("post_rst_idle", bp_bad, 0);
    run_job(8'h0F, 1'b0, 4'd4, 8'hF0);

    // A few random jobs checked against the model
    for (int i = 0; i < 6; i++) begin
      rx = 8'($urandom_range(0, 255));
      rd = 1'($urandom_range(0, 1));
      rc = 4'($urandom_range(0, 15));
      run_job(rx, rd, rc, rotn(rx, rd, int'(rc)));
    end

    check("scoreboard_leftover", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
